keyboard_controller: RTL and testbench

KEYBOARD_CONTROLLER -- requirements
Module: keyboard_controller

---
 rtl/kb_pkg.sv | 30 +++
 rtl/ps2_rx.sv | 149 ++++++++++++++
 rtl/keyboard_controller.sv | 67 ++++++
 tb/tb_keyboard_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/kb_pkg.sv
// rtl/kb_pkg.sv - shared PS/2 receiver states and scan-code constants
package kb_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    // Keyboard status/handshake bytes that never name a key
    localparam logic [7:0] IGN_ERR0   = 8'h00;
    localparam logic [7:0] IGN_BAT    = 8'hAA;
    localparam logic [7:0] IGN_ECHO   = 8'hEE;
    localparam logic [7:0] IGN_ACK    = 8'hFA;
    localparam logic [7:0] IGN_BATERR = 8'hFC;
    localparam logic [7:0] IGN_RESEND = 8'hFE;
    localparam logic [7:0] IGN_ERR1   = 8'hFF;

    function automatic logic is_ignored_code(input logic [7:0] code);
        return (code == IGN_ERR0)   || (code == IGN_BAT)    ||
               (code == IGN_ECHO)   || (code == IGN_ACK)    ||
               (code == IGN_BATERR) || (code == IGN_RESEND) ||
               (code == IGN_ERR1);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 frame receiver: sync, clock filter, framing FSM, timeout
module ps2_rx
    import kb_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code_o,
    output logic       code_valid_o
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          filt_q, filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          strobe;

    rx_state_e     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    code_q, code_d;
    logic          code_valid_q, code_valid_d;

    // Two-flop synchronizers; idle-high lines reset to 1
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: accept a new clock level after FILTER_LEN agreeing samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_prev_q <= filt_q;
            if (clk_s2_q == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_q     <= clk_s2_q;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end
    end

    assign strobe = filt_prev_q & ~filt_q;

    // Framing FSM next-state, including the partial-frame timeout
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        code_d       = code_q;
        code_valid_d = 1'b0;

        if (state_q == RX_IDLE || strobe) begin
            tmo_d = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        case (state_q)
            RX_IDLE: begin
                if (strobe && !dat_s2_q) begin
                    state_d  = RX_DATA;
                    bitcnt_d = 3'd0;
                end
            end
            RX_DATA: begin
                if (strobe) begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end
                end
            end
            RX_PARITY: begin
                if (strobe) begin
                    parity_d = dat_s2_q;
                    state_d  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (strobe) begin
                    if (dat_s2_q && (^{shift_q, parity_q})) begin
                        code_valid_d = 1'b1;
                        code_d       = shift_q;
                    end
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        if (state_q != RX_IDLE && !strobe && tmo_q == TMO_LAST) begin
            state_d = RX_IDLE;
            tmo_d   = '0;
        end
    end

    // Framing FSM state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= RX_IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = code_valid_q;

endmodule

// File: rtl/keyboard_controller.sv
// rtl/keyboard_controller.sv - PS/2 keyboard top: receiver plus make/break decoder
module keyboard_controller
    import kb_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] pressedKey
);

    logic [7:0] code;
    logic       code_valid;
    logic [7:0] key_q, key_d;
    logic       break_q, break_d;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk_i        (CLK),
        .rst_ni       (RESET_N),
        .ps2_clk_i    (PS2_CLK),
        .ps2_data_i   (PS2_DATA),
        .code_o       (code),
        .code_valid_o (code_valid)
    );

    // Decode make/break sequences; E0 prefix is dropped so extended keys report base code
    always_comb begin
        key_d   = key_q;
        break_d = break_q;
        if (code_valid) begin
            if (code == EXT_CODE) begin
                key_d = key_q;
            end else if (code == BREAK_CODE) begin
                break_d = 1'b1;
            end else if (is_ignored_code(code)) begin
                break_d = 1'b0;
            end else if (break_q) begin
                break_d = 1'b0;
                if (code == key_q) begin
                    key_d = 8'h00;
                end
            end else begin
                key_d = code;
            end
        end
    end

    // Decoder registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            key_q   <= 8'h00;
            break_q <= 1'b0;
        end else begin
            key_q   <= key_d;
            break_q <= break_d;
        end
    end

    assign pressedKey = key_q;

endmodule

// File: tb/tb_keyboard_controller.sv
// tb/tb_keyboard_controller.sv - scoreboard bench for keyboard_controller
module tb_keyboard_controller;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] pressedKey;

    typedef struct {
        string      name;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    keyboard_controller #(
        .FILTER_LEN     (4),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .PS2_CLK    (PS2_CLK),
        .PS2_DATA   (PS2_DATA),
        .pressedKey (pressedKey)
    );

    always #1 CLK = ~CLK;

    task automatic expect_key(input string name, input logic [7:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    // Send the first nbits of an 11-bit frame: start, 8 data LSB first, parity, stop
    task automatic send_bits(input logic [7:0] code, input logic par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = frame[i];
            #50;
            PS2_CLK = 1'b0;
            #50;
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code);
        send_bits(code, ~^code, 11);
        #200;
    endtask

    task automatic frame_check(input string name, input logic [7:0] code, input logic [7:0] exp);
        send_frame(code);
        expect_key(name, exp);
    endtask

    // Monitor: compare the settled output against each queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (pressedKey === e.val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: pressedKey=%02h expected=%02h", e.name, pressedKey, e.val);
                end
            end
        end
    end

    initial begin
        int budget;
        #20;
        expect_key("reset_state", 8'h00);
        #20;
        RESET_N = 1'b1;
        #100;

        frame_check("make_75", 8'h75, 8'h75);
        frame_check("break_prefix_f0", 8'hF0, 8'h75);
        frame_check("break_75", 8'h75, 8'h00);

        send_bits(8'h1C, 1'b1, 11);
        #200;
        expect_key("bad_parity_1c", 8'h00);
        frame_check("make_1c", 8'h1C, 8'h1C);

        send_bits(8'h00, 1'b0, 5);
        #1200;
        expect_key("partial_timeout", 8'h1C);
        frame_check("after_timeout_29", 8'h29, 8'h29);

        frame_check("make_75_b", 8'h75, 8'h75);
        frame_check("f0_b", 8'hF0, 8'h75);
        frame_check("break_other_6b", 8'h6B, 8'h75);
        frame_check("ext_prefix_e0", 8'hE0, 8'h75);
        frame_check("ext_make_74", 8'h74, 8'h74);

        frame_check("f0_c", 8'hF0, 8'h74);
        frame_check("ignored_aa", 8'hAA, 8'h74);
        frame_check("make_after_aa", 8'h74, 8'h74);

        frame_check("e0_d", 8'hE0, 8'h74);
        frame_check("f0_d", 8'hF0, 8'h74);
        frame_check("ext_break_74", 8'h74, 8'h00);

        frame_check("make_1c_b", 8'h1C, 8'h1C);
        send_bits(8'h75, 1'b0, 5);
        RESET_N = 1'b0;
        #10;
        expect_key("reset_mid_frame", 8'h00);
        #20;
        RESET_N = 1'b1;
        #200;
        frame_check("make_75_after_reset", 8'h75, 8'h75);

        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            @(posedge CLK);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        #4;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
